// File: rtl/accumulation_buffer_drain_if.sv
// Drain-engine bus: write-back read port of the accumulation buffer plus the
// valid/ready output stream toward the DRAM side.
interface accumulation_buffer_drain_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 9
);
    logic                       ren_wb;
    logic [BANK_ADDR_WIDTH-1:0] radr_wb;
    logic [DATA_WIDTH-1:0]      rdata_wb;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output ren_wb,
        output radr_wb,
        input  rdata_wb,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  ren_wb,
        input  radr_wb,
        output rdata_wb,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/accumulation_buffer_drain.sv
// Streams words 0..num_words-1 of the write-back bank out over valid/ready,
// using a 2-entry skid FIFO to hide the buffer's 1-cycle read latency.
module accumulation_buffer_drain #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BANK_ADDR_WIDTH:0] num_words,
    output logic                     busy,
    output logic                     done,
    accumulation_buffer_drain_if.master bus
);

    localparam int CW = BANK_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         len;
    logic [CW-1:0]         rcnt;
    logic [CW-1:0]         acnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  pop;
    logic                  issue;
    logic                  credit_ok;
    logic                  last_accept;

    assign pop         = (occ != 2'd0) && bus.out_ready;
    assign last_accept = pop && (acnt == len - ONE);

    // A read may issue only if the FIFO can hold it once the in-flight word lands.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign bus.ren_wb    = issue;
    assign bus.radr_wb   = rcnt[BANK_ADDR_WIDTH-1:0];
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words != '0) ? DRAIN : FLUSH;
                end
            end
            DRAIN: begin
                if (issue && (rcnt + ONE == len)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            DRAIN: begin
                busy  = 1'b1;
                issue = (rcnt < len) && credit_ok;
            end
            FLUSH: begin
                busy = 1'b1;
                done = (len == '0) ? 1'b1 : last_accept;
            end
            default: ;
        endcase
    end

    // Counters and skid FIFO; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            rcnt        <= '0;
            acnt        <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (state == IDLE && start) begin
                len  <= num_words;
                rcnt <= '0;
                acnt <= '0;
            end else begin
                if (issue) begin
                    rcnt <= rcnt + ONE;
                end
                if (pop) begin
                    acnt <= acnt + ONE;
                end
            end
            inflight <= issue;
            if (inflight) begin
                fifo_mem[wr_ptr] <= bus.rdata_wb;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_accumulation_buffer_drain.sv
// Directed bench for accumulation_buffer_drain with a small double-banked
// accumulation buffer model supplying the write-back read port.
module tb_accumulation_buffer_drain;

    localparam logic [63:0] A5_BASE = 64'hA5A5_0000_0000_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] num_words;
    logic       busy;
    logic       done;

    logic        wen;
    logic [8:0]  wadr;
    logic [63:0] wdata;
    logic        switch_banks;
    logic        acc_sel = 1'b0;
    logic [63:0] bank [2][512];

    int errors = 0;
    int checks = 0;

    accumulation_buffer_drain_if #(.DATA_WIDTH(64), .BANK_ADDR_WIDTH(9)) bus ();

    accumulation_buffer_drain #(.DATA_WIDTH(64), .BANK_ADDR_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    // Buffer model: writes fill the accumulation bank, reads come from the other one.
    always @(posedge clk) begin
        if (wen) bank[acc_sel][wadr] <= wdata;
        if (switch_banks) acc_sel <= ~acc_sel;
        if (bus.ren_wb) bus.rdata_wb <= bank[~acc_sel][bus.radr_wb];
        else            bus.rdata_wb <= 64'h0BAD_0BAD_0BAD_0BAD;
    end

    task automatic write_and_switch(input int n, input logic [63:0] w0, input logic [63:0] w1, input logic use_base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wen   = 1'b1;
            wadr  = 9'(i);
            wdata = use_base ? (A5_BASE + 64'(i)) : ((i == 0) ? w0 : w1);
        end
        @(negedge clk);
        wen          = 1'b0;
        switch_banks = 1'b1;
        @(negedge clk);
        switch_banks = 1'b0;
    endtask

    task automatic pulse_start(input logic [9:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.ren_wb !== 1'b0) begin errors++; $display("[TB] FAIL reset ren_wb got %b exp 0", bus.ren_wb); end
        checks++; if (bus.radr_wb !== 9'd0) begin errors++; $display("[TB] FAIL reset radr_wb got %0d exp 0", bus.radr_wb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done got %b exp 0", done); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'd0) begin errors++; $display("[TB] FAIL reset out_data got %h exp 0", bus.out_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate;
        bus.out_ready = 1'b1;
        pulse_start(10'd8);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.ren_wb !== (c < 8)) begin errors++; $display("[TB] FAIL full_rate ren c=%0d got %b exp %b", c, bus.ren_wb, (c < 8)); end
            if (c < 8) begin
                checks++; if (bus.radr_wb !== 9'(c)) begin errors++; $display("[TB] FAIL full_rate radr c=%0d got %0d exp %0d", c, bus.radr_wb, c); end
            end
            checks++; if (bus.out_valid !== (c >= 2 && c <= 9)) begin errors++; $display("[TB] FAIL full_rate valid c=%0d got %b", c, bus.out_valid); end
            if (c >= 2 && c <= 9) begin
                checks++; if (bus.out_data !== A5_BASE + 64'(c - 2)) begin errors++; $display("[TB] FAIL full_rate data c=%0d got %h exp %h", c, bus.out_data, A5_BASE + 64'(c - 2)); end
            end
            checks++; if (done !== (c == 9)) begin errors++; $display("[TB] FAIL full_rate done c=%0d got %b", c, done); end
            checks++; if (busy !== (c <= 9)) begin errors++; $display("[TB] FAIL full_rate busy c=%0d got %b", c, busy); end
        end
    endtask

    task automatic test_backpressure;
        int rdy_tab [10] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
        int ren_tab [10] = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 0};
        int adr_tab [10] = '{0, 1, 0, 2, 0, 3, 4, 0, 0, 0};
        int val_tab [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        int dat_tab [10] = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 0};
        pulse_start(10'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.out_ready = rdy_tab[c][0];
            #1;
            checks++; if (bus.ren_wb !== ren_tab[c][0]) begin errors++; $display("[TB] FAIL backpressure ren c=%0d got %b exp %0d", c, bus.ren_wb, ren_tab[c]); end
            if (ren_tab[c] == 1) begin
                checks++; if (bus.radr_wb !== 9'(adr_tab[c])) begin errors++; $display("[TB] FAIL backpressure radr c=%0d got %0d exp %0d", c, bus.radr_wb, adr_tab[c]); end
            end
            checks++; if (bus.out_valid !== val_tab[c][0]) begin errors++; $display("[TB] FAIL backpressure valid c=%0d got %b exp %0d", c, bus.out_valid, val_tab[c]); end
            if (val_tab[c] == 1) begin
                checks++; if (bus.out_data !== A5_BASE + 64'(dat_tab[c])) begin errors++; $display("[TB] FAIL backpressure data c=%0d got %h exp %h", c, bus.out_data, A5_BASE + 64'(dat_tab[c])); end
            end
            checks++; if (done !== (c == 8)) begin errors++; $display("[TB] FAIL backpressure done c=%0d got %b", c, done); end
            checks++; if (busy !== (c <= 8)) begin errors++; $display("[TB] FAIL backpressure busy c=%0d got %b", c, busy); end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_zero_length;
        pulse_start(10'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.ren_wb !== 1'b0) begin errors++; $display("[TB] FAIL zero_len ren c=%0d got %b exp 0", c, bus.ren_wb); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_len valid c=%0d got %b exp 0", c, bus.out_valid); end
            checks++; if (done !== (c == 0)) begin errors++; $display("[TB] FAIL zero_len done c=%0d got %b", c, done); end
            checks++; if (busy !== (c == 0)) begin errors++; $display("[TB] FAIL zero_len busy c=%0d got %b", c, busy); end
        end
    endtask

    task automatic test_start_while_busy;
        int pops = 0;
        int dones = 0;
        pulse_start(10'd8);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            start     = (c == 3 || c == 9);
            num_words = 10'd3;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_data !== A5_BASE + 64'(pops)) begin errors++; $display("[TB] FAIL busy_start data word=%0d got %h exp %h", pops, bus.out_data, A5_BASE + 64'(pops)); end
                pops++;
            end
            if (done) dones++;
            if (c == 9) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL busy_start done_cycle got %b exp 1", done); end
            end
            if (c >= 10) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start busy_after c=%0d got %b exp 0", c, busy); end
                checks++; if (bus.ren_wb !== 1'b0) begin errors++; $display("[TB] FAIL busy_start ren_after c=%0d got %b exp 0", c, bus.ren_wb); end
            end
        end
        start = 1'b0;
        checks++; if (pops !== 8) begin errors++; $display("[TB] FAIL busy_start words got %0d exp 8", pops); end
        checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL busy_start done_count got %0d exp 1", dones); end
    endtask

    task automatic test_reset_mid_drain;
        pulse_start(10'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
        end
        checks++; if (bus.radr_wb !== 9'd2 || bus.ren_wb !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset issue2 got ren=%b adr=%0d exp ren=1 adr=2", bus.ren_wb, bus.radr_wb); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ren_wb !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset ren got %b exp 0", bus.ren_wb); end
        checks++; if (bus.radr_wb !== 9'd0) begin errors++; $display("[TB] FAIL mid_reset radr got %0d exp 0", bus.radr_wb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset done got %b exp 0", done); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'd0) begin errors++; $display("[TB] FAIL mid_reset data got %h exp 0", bus.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset post_valid got %b exp 0", bus.out_valid); end
        pulse_start(10'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.ren_wb !== (c < 2)) begin errors++; $display("[TB] FAIL mid_reset restart_ren c=%0d got %b", c, bus.ren_wb); end
            if (c < 2) begin
                checks++; if (bus.radr_wb !== 9'(c)) begin errors++; $display("[TB] FAIL mid_reset restart_radr c=%0d got %0d exp %0d", c, bus.radr_wb, c); end
            end
            checks++; if (bus.out_valid !== (c == 2 || c == 3)) begin errors++; $display("[TB] FAIL mid_reset restart_valid c=%0d got %b", c, bus.out_valid); end
            if (c == 2 || c == 3) begin
                checks++; if (bus.out_data !== A5_BASE + 64'(c - 2)) begin errors++; $display("[TB] FAIL mid_reset restart_data c=%0d got %h exp %h", c, bus.out_data, A5_BASE + 64'(c - 2)); end
            end
            checks++; if (done !== (c == 3)) begin errors++; $display("[TB] FAIL mid_reset restart_done c=%0d got %b", c, done); end
            checks++; if (busy !== (c <= 3)) begin errors++; $display("[TB] FAIL mid_reset restart_busy c=%0d got %b", c, busy); end
        end
    endtask

    task automatic test_end_to_end;
        logic [63:0] exp_w [2];
        exp_w[0] = 64'hCAFEBABE_CAFEBABE;
        exp_w[1] = 64'hDEADBEEF_DEADBEEF;
        write_and_switch(2, exp_w[0], exp_w[1], 1'b0);
        pulse_start(10'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.out_valid !== (c == 2 || c == 3)) begin errors++; $display("[TB] FAIL end_to_end valid c=%0d got %b", c, bus.out_valid); end
            if (c == 2 || c == 3) begin
                checks++; if (bus.out_data !== exp_w[c - 2]) begin errors++; $display("[TB] FAIL end_to_end data c=%0d got %h exp %h", c, bus.out_data, exp_w[c - 2]); end
            end
            checks++; if (done !== (c == 3)) begin errors++; $display("[TB] FAIL end_to_end done c=%0d got %b", c, done); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        num_words     = 10'd0;
        wen           = 1'b0;
        wadr          = 9'd0;
        wdata         = 64'd0;
        switch_banks  = 1'b0;
        bus.out_ready = 1'b0;

        test_reset();
        write_and_switch(16, 64'd0, 64'd0, 1'b1);
        test_full_rate();
        repeat (2) @(negedge clk);
        test_backpressure();
        repeat (2) @(negedge clk);
        test_zero_length();
        repeat (2) @(negedge clk);
        test_start_while_busy();
        repeat (2) @(negedge clk);
        test_reset_mid_drain();
        repeat (2) @(negedge clk);
        test_end_to_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accumulation_buffer_drain.md
# accumulation_buffer_drain

Write-back drain engine for the double-banked accumulation buffer. After a bank switch it reads the write-back bank through the buffer's `ren_wb`/`radr_wb`/`rdata_wb` port, addresses `0..num_words-1` in order. It streams each word out over a valid/ready interface toward the output/DRAM side. A 2-entry skid FIFO absorbs the buffer's 1-cycle read latency, so full-rate transfer survives arbitrary downstream backpressure. `done` tells the top-level controller the bank may be switched again.

## Interface
- `DATA_WIDTH`, 64, word width (matches accumulation buffer)
- `BANK_ADDR_WIDTH`, 9, bank address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to drain; sampled only in IDLE
- `num_words`  in  BANK_ADDR_WIDTH+1  words to drain; latched when `start` is accepted
- `busy`  out  1  high while a drain is in progress
- `done`  out  1  one-cycle pulse when the last word is accepted downstream
- `ren_wb`  out  1  read enable to the accumulation buffer write-back port
- `radr_wb`  out  BANK_ADDR_WIDTH  read address to the write-back port
- `rdata_wb`  in  DATA_WIDTH  read data, valid the cycle after `ren_wb`
- `out_data`  out  DATA_WIDTH  FIFO head word
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`

## Operation
- States: IDLE, DRAIN, FLUSH.
- **IDLE:**
  - On `start`, latch `num_words` and clear the read counter `rcnt` and the accept counter `acnt`.
  - If `num_words != 0`, go to DRAIN. If it is 0, go to FLUSH, which pulses `done` on the next cycle with no reads.
- **DRAIN:**
  - Issue condition: `ren_wb = (rcnt < len) && (occ + inflight - pop < 2)`.
    - `occ` is FIFO occupancy (0..2).
    - `inflight` is the registered `ren_wb` from the previous cycle.
    - `pop` is `out_valid && out_ready`.
  - `radr_wb = rcnt[BANK_ADDR_WIDTH-1:0]`. `rcnt` increments on each issue.
  - When `rcnt == len` after an issue, go to FLUSH.
- **FIFO write:** a FIFO write occurs whenever `inflight == 1`, capturing `rdata_wb`. The credit rule guarantees no overflow.
- **Simultaneous push and pop:** occupancy is unchanged and ordering is preserved.
- **Accept counting:** `acnt` increments on each `pop`.
- **FLUSH:** when `pop` occurs and `acnt == len-1` (the last word), assert `done` for that cycle and return to IDLE. For `len == 0`, `done` is asserted on the first FLUSH cycle.
- **busy:** high in DRAIN and FLUSH, including the `done` cycle. Low in IDLE.
- **Ignored starts:** `start` in DRAIN or FLUSH is ignored. `start` in the same cycle as `done` is also ignored.
- **Range:** `num_words` above `2^BANK_ADDR_WIDTH` is not supported and is not checked. `num_words = 2^BANK_ADDR_WIDTH` drains the full range, with addresses wrapping only after the last issue.
- **Bank switching:** this block never drives `switch_banks`. The controller must not switch banks while `busy`.

## Timing
- **Reset values:** `ren_wb=0`, `radr_wb=0`, `busy=0`, `done=0`, `out_valid=0`, `out_data=0`. State returns to IDLE, FIFO is emptied, counters and `inflight` are cleared.
- **Reset mid-drain:** an in-flight read is discarded, and `rdata_wb` on the cycle after reset deassertion is not captured.
- **Start latency:** with `start` sampled at edge E0, `ren_wb`/`radr_wb=0` are high during cycle E0–E1.
- **First output:** `rdata_wb` is valid E1–E2, captured at E2, and `out_valid` rises after E2. Start to first `out_valid` is 2 cycles.
- **Throughput:** with `out_ready` held high, one word per cycle sustained. A drain of N words finishes with `done` N+1 cycles after E0.
- **Backpressure:**
  - While `out_ready=0`, at most 2 words are buffered and `ren_wb` stays low once `occ + inflight = 2`.
  - `out_data`/`out_valid` hold stable until accepted.
  - Reads resume in the same cycle a pop frees a slot.
- **Read data:** `rdata_wb` is sampled only the cycle after `ren_wb`. Its value at other times is don't-care.

## Test plan
- **Full-rate drain:** bank preloaded with `mem[i] = 64'hA5A5_0000_0000_0000 + i`; `start` with `num_words=8` and `out_ready=1`.
  - `radr_wb` = 0..7 on consecutive cycles.
  - `out_data` = `...0000..0007` on consecutive cycles.
  - `done` pulse 9 cycles after start; `busy` low next cycle.
- **Backpressure:** `num_words=5`, `out_ready` toggles 1,0,0,1,0,1,1,1.
  - Every word is delivered exactly once, in order, with no `ren_wb` while 2 words are pending.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Zero length:** `num_words=0` → no `ren_wb` ever; `done` pulse 1 cycle after start; `out_valid` stays 0.
- **Start while busy:** a second `start` with `num_words=3` during an 8-word drain is ignored. Exactly 8 words are delivered and exactly one `done`.
- **Reset mid-drain:** `rst_n` low for 1 cycle after word 2 is issued.
  - All outputs are at reset values; the FIFO is empty.
  - A new `start` with `num_words=2` delivers `mem[0]`, `mem[1]` with correct timing.
- **End to end with accumulation_buffer:** write `64'hCAFEBABE_CAFEBABE` to address 0 and `64'hDEADBEEF_DEADBEEF` to address 1, `switch_banks`, `start` with `num_words=2` → the stream outputs both words in order, then `done`.
